camera_frame_writer: RTL

// - Captures one YCbCr 4:2:2 camera frame into an external single-port frame-buffer BRAM.
// - Each 32-bit camera word is unpacked into two 24-bit {Y,Cb,Cr} pixels, and the pixels are written at sequential addresses.
// - Capture is armed by the host and aligned to the camera vsync.
// - frame_done signals that a frame is complete.
// - Sits between the camera word assembler (pixel_done/data_in) and the frame BRAM; display logic reads that BRAM.

---
 rtl/camera_frame_writer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/camera_frame_writer.sv
// camera_frame_writer
// Captures one YCbCr 4:2:2 camera frame into a single-port frame-buffer BRAM.
// Each 32-bit word {Cb, Y0, Cr, Y1} becomes two pixels written at consecutive
// addresses. Capture is armed by the host and starts on a vsync rising edge.
//
// Optional build macro: CAPTURE_LUMA_ONLY_EN
//   defined   -> PIX_W = 8, only Y0 then Y1 are stored
//   undefined -> PIX_W = 24, pixels are {Y, Cb, Cr}
//
// Ports
//   i_clk          system clock, all logic on posedge
//   i_reset        synchronous active-high reset
//   i_arm          1-cycle pulse: capture the next frame
//   i_vsync        camera vsync (already in i_clk domain), rising edge = frame start
//   i_pixel_done   1-cycle strobe, i_data_in valid
//   i_data_in      {Cb[31:24], Y0[23:16], Cr[15:8], Y1[7:0]}
//   o_bram_addr    BRAM write address
//   o_bram_din     BRAM write pixel (PIX_W bits)
//   o_bram_we      BRAM write enable, one pixel per cycle
//   o_busy         high while waiting for vsync or capturing
//   o_frame_done   frame complete (level when CONTINUOUS=0, 1-cycle pulse otherwise)
//   o_overflow     sticky: a word was dropped because a write was in progress
//   o_short_frame  sticky: vsync restarted a frame before it completed
module camera_frame_writer #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int CONTINUOUS   = 0,
`ifdef CAPTURE_LUMA_ONLY_EN
  localparam int PIX_W       = 8
`else
  localparam int PIX_W       = 24
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arm,
  input  logic              i_vsync,
  input  logic              i_pixel_done,
  input  logic [31:0]       i_data_in,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [PIX_W-1:0]  o_bram_din,
  output logic              o_bram_we,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_short_frame
);

  // One extra bit so the counter can hold FRAME_PIXELS when it equals 2**ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VSYNC, S_WAIT_WORD, S_WRITE_0, S_WRITE_1, S_DONE
  } state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [PIX_W-1:0]    r_pix1, w_pix1_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [PIX_W-1:0]    r_din, w_din_next;
  logic                r_we, w_we_next;
  logic                r_overflow, w_overflow_next;
  logic                r_short_frame, w_short_next;
  logic                r_vsync_q;

  logic                w_vs_rise;
  logic                w_frame_end;
  logic [PIX_W-1:0]    w_pix0;
  logic [PIX_W-1:0]    w_pix1;

  assign w_vs_rise = i_vsync & ~r_vsync_q;
  // In WRITE_0/WRITE_1 r_cnt already points past the pixel on the port, so
  // reaching FRAME_PIXELS means the last pixel of the frame is being written.
  assign w_frame_end = (r_cnt == LAST_CNT);

`ifdef CAPTURE_LUMA_ONLY_EN
  logic w_chroma_unused;
  assign w_chroma_unused = ^{i_data_in[31:24], i_data_in[15:8]};
  assign w_pix0 = i_data_in[23:16];
  assign w_pix1 = i_data_in[7:0];
`else
  assign w_pix0 = {i_data_in[23:16], i_data_in[31:24], i_data_in[15:8]};
  assign w_pix1 = {i_data_in[7:0],   i_data_in[31:24], i_data_in[15:8]};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pix1        <= '0;
      r_addr        <= '0;
      r_din         <= '0;
      r_we          <= 1'b0;
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
      r_vsync_q     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_pix1        <= w_pix1_next;
      r_addr        <= w_addr_next;
      r_din         <= w_din_next;
      r_we          <= w_we_next;
      r_overflow    <= w_overflow_next;
      r_short_frame <= w_short_next;
      r_vsync_q     <= i_vsync;
    end
  end

  // Outputs are registered: the cycle a word is accepted loads the write
  // port for the following cycle, giving pix0 at N+1 and pix1 at N+2.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_pix1_next     = r_pix1;
    w_addr_next     = r_addr;
    w_din_next      = r_din;
    w_we_next       = 1'b0;
    w_overflow_next = r_overflow;
    w_short_next    = r_short_frame;

    case (r_state)
      S_IDLE: begin
        if (i_arm || (CONTINUOUS != 0)) begin
          w_state_next = S_WAIT_VSYNC;
        end
        if (i_arm) begin
          w_overflow_next = 1'b0;
          w_short_next    = 1'b0;
        end
      end

      S_WAIT_VSYNC: begin
        if (w_vs_rise) begin
          w_state_next = S_WAIT_WORD;
          w_cnt_next   = '0;
        end
      end

      S_WAIT_WORD: begin
        if (w_vs_rise) begin
          w_state_next = S_WAIT_WORD;
          w_cnt_next   = '0;
          w_short_next = 1'b1;
        end else if (i_pixel_done) begin
          w_state_next = S_WRITE_0;
          w_we_next    = 1'b1;
          w_addr_next  = r_cnt[ADDR_W-1:0];
          w_din_next   = w_pix0;
          w_pix1_next  = w_pix1;
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end

      S_WRITE_0: begin
        // A word arriving while pix1 is still queued cannot be held.
        if (i_pixel_done && !(w_vs_rise && !w_frame_end)) begin
          w_overflow_next = 1'b1;
        end
        if (w_frame_end) begin
          w_state_next = S_DONE;
        end else if (w_vs_rise) begin
          w_state_next = S_WAIT_WORD;
          w_cnt_next   = '0;
          w_short_next = 1'b1;
        end else begin
          w_state_next = S_WRITE_1;
          w_we_next    = 1'b1;
          w_addr_next  = r_cnt[ADDR_W-1:0];
          w_din_next   = r_pix1;
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end

      S_WRITE_1: begin
        if (w_frame_end) begin
          w_state_next = S_DONE;
        end else if (w_vs_rise) begin
          w_state_next = S_WAIT_WORD;
          w_cnt_next   = '0;
          w_short_next = 1'b1;
        end else if (i_pixel_done) begin
          w_state_next = S_WRITE_0;
          w_we_next    = 1'b1;
          w_addr_next  = r_cnt[ADDR_W-1:0];
          w_din_next   = w_pix0;
          w_pix1_next  = w_pix1;
          w_cnt_next   = r_cnt + CNT_W'(1);
        end else begin
          w_state_next = S_WAIT_WORD;
        end
      end

      S_DONE: begin
        if (CONTINUOUS != 0) begin
          w_state_next = S_WAIT_VSYNC;
        end else if (i_arm) begin
          w_state_next    = S_WAIT_VSYNC;
          w_overflow_next = 1'b0;
          w_short_next    = 1'b0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_bram_addr   = r_addr;
  assign o_bram_din    = r_din;
  assign o_bram_we     = r_we;
  assign o_busy        = (r_state == S_WAIT_VSYNC) || (r_state == S_WAIT_WORD) ||
                         (r_state == S_WRITE_0)    || (r_state == S_WRITE_1);
  assign o_frame_done  = (r_state == S_DONE);
  assign o_overflow    = r_overflow;
  assign o_short_frame = r_short_frame;

endmodule
